// File: rtl/mc_sequencer_if.sv
// ---------------------------------------------------------------------------
// mc_sequencer_if -- control bus between the multi-cycle datapath and its
// sequencer.
//
// Parameters : CNT_W (performance counter width), OPW (opcode width)
// master     : datapath side; drives opcode/zero/imem_ready/dmem_ready/run,
//              observes state, strobes, pc_src and the counters.
// slave      : sequencer side (mc_sequencer).
// ---------------------------------------------------------------------------
interface mc_sequencer_if #(
    parameter int CNT_W = 32,
    parameter int OPW   = 6
);
    // datapath -> sequencer
    logic [OPW-1:0]   opcode;
    logic             zero;
    logic             imem_ready;
    logic             dmem_ready;
    logic             run;
    // sequencer -> datapath
    logic [2:0]       state;
    logic             pc_we;
    logic             ir_we;
    logic             reg_we;
    logic             link;
    logic             dmem_re;
    logic             dmem_we;
    logic [1:0]       pc_src;
    logic             instr_done;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        output opcode, zero, imem_ready, dmem_ready, run,
        input  state, pc_we, ir_we, reg_we, link, dmem_re, dmem_we,
               pc_src, instr_done, cycle_cnt, instr_cnt
    );

    modport slave (
        input  opcode, zero, imem_ready, dmem_ready, run,
        output state, pc_we, ir_we, reg_we, link, dmem_re, dmem_we,
               pc_src, instr_done, cycle_cnt, instr_cnt
    );
endinterface

// File: rtl/mc_sequencer.sv
// ---------------------------------------------------------------------------
// mc_sequencer -- multi-cycle CPU control sequencer.
//
// Walks each instruction through IF/ID/EXE/MEM/WB according to its opcode
// class and produces the datapath strobes for every cycle. All strobes are
// combinational in state, opcode, zero and the ready inputs.
//
// Ports:
//   clk   : clock, rising edge
//   clear : asynchronous active-high reset (state -> IF, counters -> 0)
//   bus   : mc_sequencer_if.slave (opcode/zero/ready/run in; state,
//           pc_we, ir_we, reg_we, link, dmem_re, dmem_we, pc_src,
//           instr_done, cycle_cnt, instr_cnt out)
//
// Parameters: CNT_W (8..64), OPW (>=6, encodings left-aligned), HALT_RESUME.
// Optional feature: define MC_PERF_CNT_EN to build the saturating cycle and
// instruction counters; otherwise the counter outputs are tied to zero.
// ---------------------------------------------------------------------------
module mc_sequencer #(
    parameter int CNT_W       = 32,
    parameter int OPW         = 6,
    parameter bit HALT_RESUME = 1'b0
) (
    input logic           clk,
    input logic           clear,
    mc_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EXE  = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        C_NOP, C_ALU, C_LW, C_SW, C_BEQ, C_J, C_JR, C_JAL, C_HALT
    } cls_e;

    state_e     state_q, state_d;
    cls_e       cls;
    logic [5:0] op6;

    logic       pc_we, ir_we, reg_we, link, dmem_re, dmem_we, instr_done;
    logic [1:0] pc_src;

    // Only the top six opcode bits carry the class encoding.
    assign op6 = bus.opcode[OPW-1 -: 6];

    always_comb begin
        cls = C_NOP;
        case (op6)
            6'b000000, 6'b000001, 6'b000010,
            6'b010000, 6'b010001: cls = C_ALU;
            6'b110001:            cls = C_LW;
            6'b110000:            cls = C_SW;
            6'b110100:            cls = C_BEQ;
            6'b111000:            cls = C_J;
            6'b111001:            cls = C_JR;
            6'b111010:            cls = C_JAL;
            6'b111111:            cls = C_HALT;
            default:              cls = C_NOP;
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) state_q <= ST_IF;
        else       state_q <= state_d;
    end

    // 'fin' marks the last cycle of an instruction: PC update, done pulse,
    // and return to IF all happen together.
    always_comb begin
        logic fin;
        fin      = 1'b0;
        state_d  = state_q;
        ir_we    = 1'b0;
        reg_we   = 1'b0;
        link     = 1'b0;
        dmem_re  = 1'b0;
        dmem_we  = 1'b0;
        pc_src   = 2'b00;
        case (state_q)
            ST_IF: begin
                // opcode still holds the previous instruction here; ignore it
                if (bus.imem_ready && !clear) begin
                    ir_we   = 1'b1;
                    state_d = ST_ID;
                end
            end
            ST_ID: begin
                case (cls)
                    C_ALU, C_LW, C_SW, C_BEQ: state_d = ST_EXE;
                    C_HALT:                   state_d = ST_HALT;
                    C_J: begin
                        pc_src = 2'b11;
                        fin    = 1'b1;
                    end
                    C_JAL: begin
                        pc_src = 2'b11;
                        reg_we = 1'b1;
                        link   = 1'b1;
                        fin    = 1'b1;
                    end
                    C_JR: begin
                        pc_src = 2'b10;
                        fin    = 1'b1;
                    end
                    default: fin = 1'b1;
                endcase
            end
            ST_EXE: begin
                case (cls)
                    C_ALU:      state_d = ST_WB;
                    C_LW, C_SW: state_d = ST_MEM;
                    default: begin
                        // BEQ ends here; taken only on zero
                        if (cls == C_BEQ && bus.zero) pc_src = 2'b01;
                        fin = 1'b1;
                    end
                endcase
            end
            ST_MEM: begin
                dmem_re = (cls == C_LW);
                dmem_we = (cls == C_SW);
                if (bus.dmem_ready) begin
                    if (cls == C_LW) state_d = ST_WB;
                    else             fin     = 1'b1;
                end
            end
            ST_WB: begin
                reg_we = 1'b1;
                fin    = 1'b1;
            end
            ST_HALT: begin
                if (HALT_RESUME && bus.run) fin = 1'b1;
            end
            default: state_d = ST_IF;  // unused encodings 6/7 recover
        endcase
        if (fin) state_d = ST_IF;
        pc_we      = fin;
        instr_done = fin;
    end

    assign bus.state      = state_q;
    assign bus.pc_we      = pc_we;
    assign bus.ir_we      = ir_we;
    assign bus.reg_we     = reg_we;
    assign bus.link       = link;
    assign bus.dmem_re    = dmem_re;
    assign bus.dmem_we    = dmem_we;
    assign bus.pc_src     = pc_src;
    assign bus.instr_done = instr_done;

`ifdef MC_PERF_CNT_EN
    logic [CNT_W-1:0] cyc_q, ins_q;

    // Saturating counters; cycle_cnt freezes while halted.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            cyc_q <= '0;
            ins_q <= '0;
        end else begin
            if (state_q != ST_HALT && cyc_q != '1) cyc_q <= cyc_q + CNT_W'(1);
            if (instr_done && ins_q != '1)          ins_q <= ins_q + CNT_W'(1);
        end
    end

    assign bus.cycle_cnt = cyc_q;
    assign bus.instr_cnt = ins_q;
`else
    assign bus.cycle_cnt = '0;
    assign bus.instr_cnt = '0;
`endif

endmodule
